// File: rtl/op_scheduler_if.sv
// Host command, controller issue and completion signals of op_scheduler.
// The scheduler uses the master modport; the host/controller side uses slave.
interface op_scheduler_if #(
  parameter int ADDR_WIDTH  = 10,
  parameter int TAG_WIDTH   = 4,
  parameter int DEPTH_WIDTH = 2
) ();
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_opcode;
  logic [ADDR_WIDTH-1:0]  cmd_op1_addr;
  logic [ADDR_WIDTH-1:0]  cmd_op2_addr;
  logic [ADDR_WIDTH-1:0]  cmd_out_addr;
  logic [TAG_WIDTH-1:0]   cmd_tag;

  logic                   ctrl_config_en;
  logic [1:0]             ctrl_opcode;
  logic [ADDR_WIDTH-1:0]  ctrl_op1_base_addr;
  logic [ADDR_WIDTH-1:0]  ctrl_op2_base_addr;
  logic [ADDR_WIDTH-1:0]  ctrl_out_base_addr;
  logic                   ctrl_done;

  logic                   cpl_valid;
  logic                   cpl_ready;
  logic [TAG_WIDTH-1:0]   cpl_tag;
  logic                   cpl_error;

  logic                   busy;
  logic [DEPTH_WIDTH:0]   queue_count;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_op1_addr, cmd_op2_addr, cmd_out_addr, cmd_tag,
    output cmd_ready,
    output ctrl_config_en, ctrl_opcode, ctrl_op1_base_addr, ctrl_op2_base_addr,
           ctrl_out_base_addr,
    input  ctrl_done,
    output cpl_valid, cpl_tag, cpl_error,
    input  cpl_ready,
    output busy, queue_count
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_op1_addr, cmd_op2_addr, cmd_out_addr, cmd_tag,
    input  cmd_ready,
    input  ctrl_config_en, ctrl_opcode, ctrl_op1_base_addr, ctrl_op2_base_addr,
           ctrl_out_base_addr,
    output ctrl_done,
    input  cpl_valid, cpl_tag, cpl_error,
    output cpl_ready,
    input  busy, queue_count
  );
endinterface

// File: rtl/op_scheduler.sv
// Command FIFO plus one-at-a-time issue sequencer for the LWE arithmetic controller.
// Optional RUN watchdog enabled by defining OP_SCHED_TIMEOUT_EN.
module op_scheduler #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TAG_WIDTH      = 4,
  parameter int DEPTH          = 4,
  parameter int DEPTH_WIDTH    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic           clk,
  input logic           rst_n,
  op_scheduler_if.master bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, RUN, CPL} state_e;

  typedef struct packed {
    logic [1:0]            opcode;
    logic [ADDR_WIDTH-1:0] op1;
    logic [ADDR_WIDTH-1:0] op2;
    logic [ADDR_WIDTH-1:0] out;
    logic [TAG_WIDTH-1:0]  tag;
  } cmd_t;

  localparam logic [DEPTH_WIDTH:0] FULL_COUNT = (DEPTH_WIDTH+1)'(DEPTH);

  cmd_t                   mem_q [DEPTH];
  cmd_t                   cmd_in;
  cmd_t                   issue_q;
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   count_q, count_d;
  state_e                 state_q;
  logic                   config_en_q;
  logic                   cpl_valid_q;
  logic [TAG_WIDTH-1:0]   cpl_tag_q;
  logic                   push, pop;

  assign cmd_in = {bus.cmd_opcode, bus.cmd_op1_addr, bus.cmd_op2_addr,
                   bus.cmd_out_addr, bus.cmd_tag};

  // Ready depends only on registered occupancy, so a same-cycle pop never opens it.
  assign bus.cmd_ready = (count_q != FULL_COUNT);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state_q == IDLE) && (count_q != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is left unreset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

`ifdef OP_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] run_cnt_q;
  logic             cpl_error_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_q     <= '0;
      config_en_q <= 1'b0;
      cpl_valid_q <= 1'b0;
      cpl_tag_q   <= '0;
`ifdef OP_SCHED_TIMEOUT_EN
      run_cnt_q   <= '0;
      cpl_error_q <= 1'b0;
`endif
    end else begin
      config_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            issue_q     <= mem_q[rd_ptr_q];
            config_en_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: state_q <= SETTLE;
        // Done seen here is the previous op's stale level; it is not looked at.
        SETTLE: begin
          state_q <= RUN;
`ifdef OP_SCHED_TIMEOUT_EN
          run_cnt_q <= '0;
`endif
        end
        RUN: begin
          if (bus.ctrl_done) begin
            state_q     <= CPL;
            cpl_valid_q <= 1'b1;
            cpl_tag_q   <= issue_q.tag;
`ifdef OP_SCHED_TIMEOUT_EN
            cpl_error_q <= 1'b0;
          end else if (run_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q     <= CPL;
            cpl_valid_q <= 1'b1;
            cpl_tag_q   <= issue_q.tag;
            cpl_error_q <= 1'b1;
          end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
`endif
          end
        end
        CPL: begin
          if (bus.cpl_ready) begin
            cpl_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ctrl_config_en     = config_en_q;
  assign bus.ctrl_opcode        = issue_q.opcode;
  assign bus.ctrl_op1_base_addr = issue_q.op1;
  assign bus.ctrl_op2_base_addr = issue_q.op2;
  assign bus.ctrl_out_base_addr = issue_q.out;
  assign bus.cpl_valid          = cpl_valid_q;
  assign bus.cpl_tag            = cpl_tag_q;
`ifdef OP_SCHED_TIMEOUT_EN
  assign bus.cpl_error          = cpl_error_q;
`else
  assign bus.cpl_error          = 1'b0;
`endif
  assign bus.busy               = (state_q != IDLE);
  assign bus.queue_count        = count_q;

endmodule

// File: tb/tb_op_scheduler.sv
// Bench for op_scheduler: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed latencies and values.
module tb_op_scheduler;
  localparam int AW = 10;
  localparam int TW = 4;
  localparam int DEPTH = 4;
  localparam int DW = 2;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  op_scheduler_if #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DEPTH_WIDTH(DW)) bus ();

  op_scheduler #(
    .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DEPTH(DEPTH), .DEPTH_WIDTH(DW),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic          cv = 1'b0;
  logic [1:0]    cop = '0;
  logic [AW-1:0] ca1 = '0, ca2 = '0, ca3 = '0;
  logic [TW-1:0] ctag = '0;
  logic          cpl_rdy = 1'b1;
  logic          done_drv = 1'b0;

  assign bus.cmd_valid    = cv;
  assign bus.cmd_opcode   = cop;
  assign bus.cmd_op1_addr = ca1;
  assign bus.cmd_op2_addr = ca2;
  assign bus.cmd_out_addr = ca3;
  assign bus.cmd_tag      = ctag;
  assign bus.cpl_ready    = cpl_rdy;
  assign bus.ctrl_done    = done_drv;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  // Controller stand-in: done drops when configured (or two negedges later when
  // stale_hold is set) and rises done_delay negedges after that; 0 means never.
  int done_delay = 0;
  int stale_hold = 0;
  int kick_req = 0, kick_seen = 0;
  int cnt = 0, hold = 0;
  always @(negedge clk) begin
    if (kick_seen != kick_req) begin
      kick_seen = kick_req;
      done_drv  = 1'b1;
    end
    if (bus.ctrl_config_en) begin
      hold = (stale_hold != 0) ? 2 : 0;
      cnt  = done_delay;
      if (hold == 0) done_drv = 1'b0;
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) done_drv = 1'b0;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) done_drv = 1'b1;
    end
  end

  // Reference model: a queue of pending commands and the lifetime of the one in flight.
  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] a1, a2, a3;
    logic [TW-1:0] tag;
  } cmd_s;

  cmd_s          mq[$];
  cmd_s          m_cur = '0;
  bit            m_fly = 0;
  int            m_age = 0;
  bit            m_cpl = 0;
  logic [TW-1:0] m_cpl_tag = '0;
  bit            m_cpl_err = 0;
  bit            model_live = 0;
  bit            can_push;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_cur = '0; m_fly = 0; m_age = 0; m_cpl = 0; m_cpl_tag = '0; m_cpl_err = 0;
    end else begin
      can_push = cv && (mq.size() != DEPTH);
      if (!m_fly && !m_cpl && mq.size() > 0) begin
        m_cur = mq.pop_front();
        m_fly = 1; m_age = 0;
      end else if (m_fly) begin
        // age 0 = issue cycle, 1 = settle cycle, >=2 = running
        if (m_age >= 2 && done_drv) begin
          m_fly = 0; m_cpl = 1; m_cpl_tag = m_cur.tag; m_cpl_err = 0;
`ifdef OP_SCHED_TIMEOUT_EN
        end else if (m_age == TIMEOUT + 1) begin
          m_fly = 0; m_cpl = 1; m_cpl_tag = m_cur.tag; m_cpl_err = 1;
`endif
        end else begin
          m_age++;
        end
      end else if (m_cpl && cpl_rdy) begin
        m_cpl = 0;
      end
      if (can_push) mq.push_back('{cop, ca1, ca2, ca3, ctag});
    end
    model_live = 1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("config_en",   bus.ctrl_config_en,     m_fly && m_age == 0);
      check("ctrl_opcode", bus.ctrl_opcode,        m_cur.op);
      check("ctrl_op1",    bus.ctrl_op1_base_addr, m_cur.a1);
      check("ctrl_op2",    bus.ctrl_op2_base_addr, m_cur.a2);
      check("ctrl_out",    bus.ctrl_out_base_addr, m_cur.a3);
      check("cpl_valid",   bus.cpl_valid,          m_cpl);
      check("cpl_tag",     bus.cpl_tag,            m_cpl_tag);
      check("cpl_error",   bus.cpl_error,          m_cpl_err);
      check("busy",        bus.busy,               m_fly || m_cpl);
      check("queue_count", bus.queue_count,        mq.size());
      check("cmd_ready",   bus.cmd_ready,          mq.size() != DEPTH);
    end
  end

  int pulses = 0;
  logic [TW-1:0] got_tags[$];
  always @(negedge clk) begin
    if (bus.ctrl_config_en) pulses++;
    if (bus.cpl_valid && bus.cpl_ready) got_tags.push_back(bus.cpl_tag);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [AW-1:0] a1, a2, a3,
                      input logic [TW-1:0] tag);
    int   tries = 0;
    logic rdy;
    cv = 1'b1; cop = op; ca1 = a1; ca2 = a2; ca3 = a3; ctag = tag;
    do begin
      @(negedge clk);
      rdy = bus.cmd_ready;
      tick();
      tries++;
    end while (!rdy && tries < 100);
    if (!rdy) check("push_timeout", rdy, 1);
    cv = 1'b0;
  endtask

  task automatic wait_cpl(output int k);
    k = 0;
    while (!bus.cpl_valid && k < 300) begin
      tick();
      k++;
    end
    if (!bus.cpl_valid) check("cpl_wait_timeout", bus.cpl_valid, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((bus.busy || bus.queue_count != 0) && k < 400) begin
      tick();
      k++;
    end
    check("idle_wait", bus.busy, 0);
  endtask

`ifdef OP_SCHED_TIMEOUT_EN
  localparam int T1_LAT = 11;
  localparam int T1_ERR = 1;
`else
  localparam int T1_LAT = 14;
  localparam int T1_ERR = 0;
`endif

  initial begin
    int k, k2, p0;
    repeat (3) tick();
    check("rst_cmd_ready",   bus.cmd_ready, 1);
    check("rst_queue_count", bus.queue_count, 0);
    check("rst_cpl_valid",   bus.cpl_valid, 0);
    check("rst_busy",        bus.busy, 0);
    rst_n = 1'b1;
    tick();

    // Single add, done 12 cycles after configure.
    done_delay = 12;
    push(2'd2, 10'h010, 10'h020, 10'h030, 4'd5);
    k = 0;
    while (!bus.ctrl_config_en && k < 20) begin tick(); k++; end
    check("t1_issue_latency", k, 1);
    check("t1_opcode", bus.ctrl_opcode, 2);
    check("t1_op1",    bus.ctrl_op1_base_addr, 'h010);
    check("t1_op2",    bus.ctrl_op2_base_addr, 'h020);
    check("t1_out",    bus.ctrl_out_base_addr, 'h030);
    wait_cpl(k2);
    check("t1_cpl_latency", k + k2, T1_LAT);
    check("t1_cpl_tag", bus.cpl_tag, 5);
    check("t1_cpl_err", bus.cpl_error, T1_ERR);
    wait_idle();
    check("t1_queue_empty", bus.queue_count, 0);

    // Five back-to-back commands with done held off.
    done_delay = 0;
    got_tags.delete();
    p0 = pulses;
    for (int i = 0; i < 5; i++)
      push(2'(i), 10'(16 * i), 10'(16 * i + 1), 10'(16 * i + 2), 4'(i));
    check("t2_full_count", bus.queue_count, 4);
    check("t2_full_ready", bus.cmd_ready, 0);
    done_delay = 2;
    kick_req++;
    k = 0;
    while (got_tags.size() < 5 && k < 400) begin tick(); k++; end
    check("t2_cpl_count", got_tags.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got_tags.size()) check("t2_tag_order", got_tags[i], i);
    check("t2_pulses", pulses - p0, 5);
    wait_idle();

    // Completion back-pressure for 10 cycles.
    cpl_rdy = 1'b0;
    push(2'd3, 10'h100, 10'h101, 10'h102, 4'd9);
    wait_cpl(k);
    push(2'd1, 10'h200, 10'h201, 10'h202, 4'd10);
    p0 = pulses;
    repeat (10) tick();
    check("t3_cpl_hold",  bus.cpl_valid, 1);
    check("t3_tag_hold",  bus.cpl_tag, 9);
    check("t3_queued",    bus.queue_count, 1);
    check("t3_no_issue",  pulses - p0, 0);
    cpl_rdy = 1'b1;
    wait_idle();

    // Stale done still high through issue and settle must not complete the op.
    stale_hold = 1;
    done_delay = 3;
    push(2'd0, 10'h3ff, 10'h000, 10'h155, 4'd3);
    wait_cpl(k);
    check("t4_stale_latency", k, 7);
    check("t4_tag", bus.cpl_tag, 3);
    stale_hold = 0;
    wait_idle();

    // Reset while running with two queued.
    done_delay = 0;
    push(2'd1, 10'h011, 10'h012, 10'h013, 4'd1);
    push(2'd2, 10'h021, 10'h022, 10'h023, 4'd2);
    push(2'd3, 10'h031, 10'h032, 10'h033, 4'd3);
    tick(); tick();
    check("t5_pre_count", bus.queue_count, 2);
    check("t5_pre_busy",  bus.busy, 1);
    rst_n = 1'b0;
    tick();
    check("t5_count",  bus.queue_count, 0);
    check("t5_ready",  bus.cmd_ready, 1);
    check("t5_busy",   bus.busy, 0);
    check("t5_cpl",    bus.cpl_valid, 0);
    check("t5_tag",    bus.cpl_tag, 0);
    check("t5_cfg",    bus.ctrl_config_en, 0);
    check("t5_fields", {bus.ctrl_opcode, bus.ctrl_op1_base_addr}, 0);
    rst_n = 1'b1;
    repeat (6) tick();
    check("t5_no_cpl", bus.cpl_valid, 0);

`ifdef OP_SCHED_TIMEOUT_EN
    // Watchdog: done never comes.
    push(2'd3, 10'h041, 10'h042, 10'h043, 4'd6);
    push(2'd0, 10'h051, 10'h052, 10'h053, 4'd7);
    wait_cpl(k);
    check("t6_timeout_latency", k, 10);
    check("t6_err", bus.cpl_error, 1);
    check("t6_tag", bus.cpl_tag, 6);
    tick();
    wait_cpl(k);
    check("t6_next_tag", bus.cpl_tag, 7);
    check("t6_next_err", bus.cpl_error, 1);
`else
    // Without watchdog RUN waits indefinitely.
    push(2'd3, 10'h041, 10'h042, 10'h043, 4'd6);
    repeat (80) tick();
    check("t6_still_waiting", bus.cpl_valid, 0);
    check("t6_still_busy", bus.busy, 1);
    kick_req++;
    wait_cpl(k);
    check("t6_tag", bus.cpl_tag, 6);
    check("t6_err", bus.cpl_error, 0);
`endif
    wait_idle();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/op_scheduler.md
# op_scheduler

Command queue and issue sequencer in front of the LWE arithmetic controller. Accepts host commands (opcode plus three base addresses plus tag) into a DEPTH-entry FIFO, issues them one at a time to the controller via a one-cycle configure pulse, waits for the controller's done, then returns a tagged completion to the host. Only one command is in flight at a time. Completions return in issue order.

## Interface
- ADDR_WIDTH, 10, width of all address fields; matches controller.
- TAG_WIDTH, 4, host-supplied command tag width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- DEPTH_WIDTH, 2, log2(DEPTH).
- TIMEOUT_CYCLES, 64, watchdog limit; used only with OP_SCHED_TIMEOUT_EN.

- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  host command offered.
- cmd_ready  out  1  FIFO can accept; equals (count != DEPTH).
- cmd_opcode  in  2  encrypt/decrypt/add/mult; passed through unchanged.
- cmd_op1_addr, cmd_op2_addr, cmd_out_addr  in  ADDR_WIDTH each  base addresses.
- cmd_tag  in  TAG_WIDTH  returned on completion.
- ctrl_config_en  out  1  one-cycle configure pulse to controller.
- ctrl_opcode  out  2; ctrl_op1_base_addr, ctrl_op2_base_addr, ctrl_out_base_addr  out  ADDR_WIDTH  issued command fields.
- ctrl_done  in  1  controller done (level).
- cpl_valid  out  1  completion available.
- cpl_ready  in  1  host accepts completion.
- cpl_tag  out  TAG_WIDTH  tag of completed command.
- cpl_error  out  1  completion was a timeout.
- busy  out  1  state != IDLE.
- queue_count  out  DEPTH_WIDTH+1  FIFO occupancy.

## Operation
- FIFO: push on cmd_valid && cmd_ready; pop only on IDLE→ISSUE. Read/write pointers wrap mod DEPTH. Push and pop in the same cycle leave count unchanged. Full blocks pushes via cmd_ready=0; a same-cycle pop does not open cmd_ready (no bypass).
- FSM states: IDLE, ISSUE, SETTLE, RUN, CPL.
  - IDLE: if count>0, pop the head into the issue registers and go to ISSUE.
  - ISSUE: ctrl_config_en=1 for exactly one cycle; go to SETTLE.
  - SETTLE: ignore ctrl_done (the controller's stale done from the prior op clears on the config edge); go to RUN.
  - RUN: on ctrl_done=1, go to CPL with cpl_error=0.
  - CPL: hold cpl_valid=1 with cpl_tag and cpl_error stable. On cpl_ready, go to IDLE.
- ctrl_opcode and ctrl_*_base_addr are driven from the issue registers at all times and change only on the IDLE→ISSUE edge.
- Reset values: state IDLE, FIFO empty, queue_count 0, cmd_ready 1, ctrl_config_en 0, all ctrl_* fields 0, cpl_valid 0, cpl_tag 0, cpl_error 0, busy 0.
- Reset mid-operation: FIFO flushed, in-flight command dropped with no completion. This block does not reset the controller; rst_n is shared.

## Timing
- Empty queue: push sampled at edge E0 → IDLE→ISSUE at E1 → ctrl_config_en high between E1 and E2 → SETTLE at E2 → RUN at E3.
- ctrl_done sampled high at edge Ed → cpl_valid high from Ed.
- cpl_valid && cpl_ready at edge Ec → IDLE at Ec. The next issue occurs no earlier than Ec+1, so there are at least 4 cycles between consecutive ctrl_config_en pulses.
- cpl_valid is never dropped without cpl_ready, except on reset.

## Configuration
- OP_SCHED_TIMEOUT_EN defined:
  - A cycle counter clears on entering RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES with ctrl_done still 0, go to CPL with cpl_error=1.
  - If ctrl_done and the limit coincide, done wins (cpl_error=0).
- Undefined: no counter, cpl_error tied 0, RUN waits indefinitely.

## Test plan
- Reset, then push one add (opcode 2, addrs 0x010/0x020/0x030, tag 5); controller done after 12 cycles → one config pulse carrying those values, cpl_valid with tag 5, cpl_error 0, queue_count back to 0.
- Push 5 commands back-to-back with DEPTH=4, done held off → cmd_ready=0 after the 4th queued; issues occur in order with tags 0..4; each config pulse is one cycle wide.
- Leave done=1 from the prior op, issue the next command → no completion until done falls and rises again.
- Hold cpl_ready=0 for 10 cycles → cpl_valid and cpl_tag stable, no new config pulse, FIFO still accepts.
- Assert rst_n=0 during RUN with 2 queued → all outputs at reset values next cycle, queue_count 0, no completion.
- With OP_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=8, never assert done → cpl_error=1 after 8 RUN cycles, then the next queued command issues.
